// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and controller-side signals for sdram_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + controller).
interface sdram_arbiter_if #(
  parameter int unsigned NPORTS = 2
);
  logic [NPORTS-1:0]    s_req;
  logic [NPORTS-1:0]    s_we;
  logic [NPORTS*24-1:0] s_addr;
  logic [NPORTS*16-1:0] s_wdata;
  logic [NPORTS-1:0]    s_ack;
  logic [15:0]          s_rdata;
  logic [NPORTS-1:0]    s_grant;
  logic [23:0]          mem_addr;
  logic [15:0]          mem_wdata;
  logic                 mem_read_req;
  logic                 mem_write_req;
  logic [15:0]          mem_rdata;
  logic                 mem_busy;
  logic                 mem_read_ready;

  modport slave (
    input  s_req, s_we, s_addr, s_wdata, mem_rdata, mem_busy, mem_read_ready,
    output s_ack, s_rdata, s_grant, mem_addr, mem_wdata, mem_read_req, mem_write_req
  );

  modport master (
    output s_req, s_we, s_addr, s_wdata, mem_rdata, mem_busy, mem_read_ready,
    input  s_ack, s_rdata, s_grant, mem_addr, mem_wdata, mem_read_req, mem_write_req
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Arbitrates NPORTS requesters onto a single-transaction SDRAM controller handshake,
// with optional fixed priority for port 0 and round-robin among the rest.
module sdram_arbiter #(
  parameter int unsigned NPORTS = 2,
  parameter bit          PRIO0  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sdram_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic              we_q;
  logic [NPORTS-1:0] ack_q;
  logic [NPORTS-1:0] grant_q;
  logic [15:0]       rdata_q;
  logic [23:0]       mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              rd_req_q;
  logic              wr_req_q;

  logic [NPORTS-1:0] elig;
  logic              win_found;
  logic              win_rr;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW:0]     cand;
  logic [IdxW-1:0]   ptr_next;
  logic [NPORTS-1:0] win_onehot;
  logic              win_we;
  logic [23:0]       win_addr;
  logic [15:0]       win_wdata;

  // A port is masked in its own ack cycle so a held request is not re-served twice.
  always_comb begin
    elig      = bus.s_req & ~ack_q;
    win_found = 1'b0;
    win_rr    = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (PRIO0 && elig[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
        cand = {1'b0, ptr_q} + (IdxW+1)'(k);
        if (cand >= (IdxW+1)'(NPORTS)) begin
          cand = cand - (IdxW+1)'(NPORTS);
        end
        if (!win_found && elig[cand[IdxW-1:0]]) begin
          win_found = 1'b1;
          win_rr    = 1'b1;
          win_idx   = cand[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_next   = (win_idx == IdxW'(NPORTS - 1)) ? '0 : win_idx + IdxW'(1);
    win_onehot = NPORTS'(1) << win_idx;
    win_we     = bus.s_we[win_idx];
    win_addr   = bus.s_addr[24*win_idx +: 24];
    win_wdata  = bus.s_wdata[16*win_idx +: 16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      ack_q       <= '0;
      grant_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (!bus.mem_busy && win_found) begin
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            we_q        <= win_we;
            grant_q     <= win_onehot;
            rd_req_q    <= ~win_we;
            wr_req_q    <= win_we;
            if (win_rr) begin
              ptr_q <= ptr_next;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (bus.mem_busy) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // Reads finish on the data pulse only; a bare busy drop is not completion.
          if (we_q ? !bus.mem_busy : bus.mem_read_ready) begin
            if (!we_q) begin
              rdata_q <= bus.mem_rdata;
            end
            ack_q   <= grant_q;
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ack         = ack_q;
  assign bus.s_rdata       = rdata_q;
  assign bus.s_grant       = grant_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_read_req  = rd_req_q;
  assign bus.mem_write_req = wr_req_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: one fixed-priority and one pure round-robin instance, each with
// its own behavioural controller; expected transactions are queued and checked on issue and ack.
module tb_sdram_arbiter;
  localparam int unsigned NP  = 3;
  localparam int unsigned Lat = 6;

  typedef struct {
    int          port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic hold_busy = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NP-1:0]    p_we    = '0;
  logic [NP*24-1:0] p_addr  = '0;
  logic [NP*16-1:0] p_wdata = '0;
  int               issue_cnt [NP];
  int               done_cnt  [2][NP];
  logic [NP-1:0]    req_v     [2];
  exp_t             sb        [2][$];

  bit               m_busy  [2];
  bit               m_rr    [2];
  bit [15:0]        m_rdata [2];

  logic             o_rd    [2];
  logic             o_wr    [2];
  logic [23:0]      o_addr  [2];
  logic [15:0]      o_wdata [2];
  logic [15:0]      o_rdata [2];
  logic [NP-1:0]    o_ack   [2];
  logic [NP-1:0]    o_grant [2];

  sdram_arbiter_if #(.NPORTS(NP)) bus_p ();
  sdram_arbiter_if #(.NPORTS(NP)) bus_r ();

  sdram_arbiter #(.NPORTS(NP), .PRIO0(1'b1)) u_dut_p (.clk(clk), .rst(rst), .bus(bus_p));
  sdram_arbiter #(.NPORTS(NP), .PRIO0(1'b0)) u_dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  assign bus_p.s_req          = req_v[0];
  assign bus_r.s_req          = req_v[1];
  assign bus_p.s_we           = p_we;
  assign bus_r.s_we           = p_we;
  assign bus_p.s_addr         = p_addr;
  assign bus_r.s_addr         = p_addr;
  assign bus_p.s_wdata        = p_wdata;
  assign bus_r.s_wdata        = p_wdata;
  assign bus_p.mem_busy       = m_busy[0] | hold_busy;
  assign bus_r.mem_busy       = m_busy[1] | hold_busy;
  assign bus_p.mem_read_ready = m_rr[0];
  assign bus_r.mem_read_ready = m_rr[1];
  assign bus_p.mem_rdata      = m_rdata[0];
  assign bus_r.mem_rdata      = m_rdata[1];

  assign o_rd[0]    = bus_p.mem_read_req;
  assign o_rd[1]    = bus_r.mem_read_req;
  assign o_wr[0]    = bus_p.mem_write_req;
  assign o_wr[1]    = bus_r.mem_write_req;
  assign o_addr[0]  = bus_p.mem_addr;
  assign o_addr[1]  = bus_r.mem_addr;
  assign o_wdata[0] = bus_p.mem_wdata;
  assign o_wdata[1] = bus_r.mem_wdata;
  assign o_rdata[0] = bus_p.s_rdata;
  assign o_rdata[1] = bus_r.s_rdata;
  assign o_ack[0]   = bus_p.s_ack;
  assign o_ack[1]   = bus_r.s_ack;
  assign o_grant[0] = bus_p.s_grant;
  assign o_grant[1] = bus_r.s_grant;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < NP; p++) begin
        req_v[g][p] = (issue_cnt[p] != done_cnt[g][p]);
      end
    end
  end

  function automatic logic [15:0] mdl_data(input logic [23:0] a);
    return (a == 24'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, inst, obs, exp);
    end
  endtask

  task automatic expect_tx(input int g, input int port, input logic we, input logic [23:0] addr,
                           input logic [15:0] wdata);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = mdl_data(addr);
    sb[g].push_back(e);
  endtask

  function automatic bit all_done();
    for (int g = 0; g < 2; g++) begin
      if (sb[g].size() != 0 || req_v[g] != '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!all_done() && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 0, 32'(all_done()), 32'd1);
    @(negedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    int          cnt = 0;
    logic        is_rd = 1'b0;
    logic [23:0] a = '0;
    logic        prev_req = 1'b0;
    logic        prev_rb = 1'b0;
    logic        prev_busy = 1'b0;
    int          fall_cyc = 0;
    int          rr_cyc = 0;
    logic [15:0] hold_rdata = '0;
    exp_t        e;
    logic        busy_now;

    assign busy_now = m_busy[g] | hold_busy;

    // Controller model: never reset, accepts one request when idle, busy for Lat cycles.
    always @(posedge clk) begin
      m_rr[g] <= 1'b0;
      if (!m_busy[g]) begin
        if ((o_rd[g] === 1'b1 || o_wr[g] === 1'b1) && !hold_busy) begin
          m_busy[g] <= 1'b1;
          cnt       <= Lat;
          is_rd     <= o_rd[g];
          a         <= o_addr[g];
        end
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else begin
        m_busy[g]  <= 1'b0;
        m_rr[g]    <= is_rd;
        m_rdata[g] <= mdl_data(a);
      end
    end

    // Requester side: samples its ack on the clock edge like a synchronous master would.
    always @(posedge clk) begin
      for (int p = 0; p < NP; p++) begin
        if (o_ack[g][p] === 1'b1) done_cnt[g][p] <= done_cnt[g][p] + 1;
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        prev_req   = 1'b0;
        prev_rb    = 1'b0;
        prev_busy  = 1'b0;
        hold_rdata = '0;
      end else begin
        if (prev_busy && !busy_now) fall_cyc = cyc;
        if (m_rr[g]) rr_cyc = cyc;
        if (prev_rb) chk("req_drop", g, 32'({o_rd[g], o_wr[g]}), 32'd0);
        if ((o_rd[g] || o_wr[g]) && !prev_req) begin
          if (sb[g].size() == 0) begin
            chk("issue_unexpected", g, 32'({o_rd[g], o_wr[g]}), 32'd0);
          end else begin
            e = sb[g][0];
            chk("issue_grant", g, 32'(o_grant[g]), 32'd1 << e.port);
            chk("issue_addr", g, 32'(o_addr[g]), 32'(e.addr));
            chk("issue_wr", g, 32'(o_wr[g]), 32'(e.we));
            chk("issue_rd", g, 32'(o_rd[g]), 32'(!e.we));
            if (e.we) chk("issue_wdata", g, 32'(o_wdata[g]), 32'(e.wdata));
          end
        end
        if (o_ack[g] !== '0) begin
          if (sb[g].size() == 0) begin
            chk("ack_unexpected", g, 32'(o_ack[g]), 32'd0);
          end else begin
            e = sb[g].pop_front();
            chk("ack_port", g, 32'(o_ack[g]), 32'd1 << e.port);
            chk("ack_grant_clr", g, 32'(o_grant[g]), 32'd0);
            if (e.we) begin
              chk("wr_rdata_hold", g, 32'(o_rdata[g]), 32'(hold_rdata));
              chk("wr_ack_lat", g, 32'(cyc), 32'(fall_cyc + 1));
            end else begin
              chk("rd_rdata", g, 32'(o_rdata[g]), 32'(e.rdata));
              chk("rd_ack_lat", g, 32'(cyc), 32'(rr_cyc + 1));
              hold_rdata = e.rdata;
            end
          end
        end
        prev_req  = o_rd[g] || o_wr[g];
        prev_rb   = prev_req && busy_now;
        prev_busy = busy_now;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int viol;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ack", g, 32'(o_ack[g]), 32'd0);
      chk("rst_grant", g, 32'(o_grant[g]), 32'd0);
      chk("rst_rdata", g, 32'(o_rdata[g]), 32'd0);
      chk("rst_addr", g, 32'(o_addr[g]), 32'd0);
      chk("rst_wdata", g, 32'(o_wdata[g]), 32'd0);
      chk("rst_reqs", g, 32'({o_rd[g], o_wr[g]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single read on port 1; address changed after grant must not matter.
    p_we[1]        = 1'b0;
    p_addr[47:24]  = 24'h000123;
    expect_tx(0, 1, 1'b0, 24'h000123, 16'h0);
    expect_tx(1, 1, 1'b0, 24'h000123, 16'h0);
    issue_cnt[1]++;
    @(negedge clk);
    chk("t1_req_lat", 0, 32'(o_rd[0]), 32'd1);
    p_addr[47:24] = 24'hFFFFFF;
    wait_done("t1_done", 100);
    chk("t1_rdata", 0, 32'(o_rdata[0]), 32'hBEEF);

    // Single write on port 0.
    p_we[0]        = 1'b1;
    p_addr[23:0]   = 24'h400010;
    p_wdata[15:0]  = 16'h1234;
    expect_tx(0, 0, 1'b1, 24'h400010, 16'h1234);
    expect_tx(1, 0, 1'b1, 24'h400010, 16'h1234);
    issue_cnt[0]++;
    wait_done("t2_done", 100);
    chk("t2_rdata_kept", 0, 32'(o_rdata[0]), 32'hBEEF);

    // Held request: exactly one transaction per ack.
    p_we[1]       = 1'b0;
    p_addr[47:24] = 24'h000200;
    for (int i = 0; i < 3; i++) begin
      expect_tx(0, 1, 1'b0, 24'h000200, 16'h0);
      expect_tx(1, 1, 1'b0, 24'h000200, 16'h0);
    end
    issue_cnt[1] += 3;
    wait_done("t5_done", 200);
    repeat (20) @(negedge clk);

    // Controller busy for 500 cycles: nothing issued meanwhile.
    hold_busy     = 1'b1;
    p_addr[47:24] = 24'h000300;
    expect_tx(0, 1, 1'b0, 24'h000300, 16'h0);
    expect_tx(1, 1, 1'b0, 24'h000300, 16'h0);
    issue_cnt[1]++;
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_rd[0] || o_wr[0] || o_rd[1] || o_wr[1] || o_grant[0] != '0 || o_grant[1] != '0)
        viol++;
    end
    chk("t4_no_issue", 0, 32'(viol), 32'd0);
    hold_busy = 1'b0;
    wait_done("t4_done", 100);

    // Contention among ports 0..2 from a fresh pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p_we = '0;
    p_addr = {24'h000030, 24'h000020, 24'h000010};
    foreach (sb[g]) sb[g].delete();
    begin
      int ord_p [6] = '{0, 1, 0, 2, 1, 2};
      int ord_r [6] = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 6; i++) begin
        expect_tx(0, ord_p[i], 1'b0, 24'h000010 * (ord_p[i] + 1), 16'h0);
        expect_tx(1, ord_r[i], 1'b0, 24'h000010 * (ord_r[i] + 1), 16'h0);
      end
    end
    for (int p = 0; p < NP; p++) issue_cnt[p] += 2;
    wait_done("t3_done", 400);

    // Reset while a read is outstanding in the controller.
    p_addr[47:24] = 24'h000400;
    expect_tx(0, 1, 1'b0, 24'h000400, 16'h0);
    expect_tx(1, 1, 1'b0, 24'h000400, 16'h0);
    issue_cnt[1]++;
    n = 0;
    while (!(m_busy[0] && !o_rd[0] && o_grant[0] != '0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_wait", 0, 32'(n < 50), 32'd1);
    rst = 1'b1;
    foreach (sb[g]) sb[g].delete();
    @(negedge clk);
    chk("t6_rst_grant", 0, 32'(o_grant[0]), 32'd0);
    chk("t6_rst_rdata", 0, 32'(o_rdata[0]), 32'd0);
    chk("t6_rst_req", 0, 32'({o_rd[0], o_wr[0]}), 32'd0);
    rst = 1'b0;
    expect_tx(0, 1, 1'b0, 24'h000400, 16'h0);
    expect_tx(1, 1, 1'b0, 24'h000400, 16'h0);
    n = 0;
    while (!m_rr[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_stale_seen", 0, 32'(m_rr[0]), 32'd1);
    chk("t6_stale_req", 0, 32'({o_rd[0], o_wr[0]}), 32'd0);
    @(negedge clk);
    chk("t6_stale_rdata", 0, 32'(o_rdata[0]), 32'd0);
    chk("t6_stale_ack", 0, 32'(o_ack[0]), 32'd0);
    wait_done("t6_done", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
